rand_num_gen: RTL and testbench
===============================

Name: rand_num_gen

Overview:
- Upstream stimulus stage for the four-input random-number compare block.
- Holds a Galois LFSR and, on request, draws four 4-bit random numbers, one per cycle.
- Presents the four numbers together on out_number1..out_number4 with a valid/ready handshake.
- The numbers feed the compare block's in_number1..in_number4 unchanged.

Parameters:
- LFSR_W, 16, LFSR state width. Must be at least 4.
- TAPS, 16'hB400, Galois feedback mask XORed into the shifted state when the shifted-out LSB is 1.
- DEFAULT_SEED, 16'hACE1, LFSR value after reset. Also substituted whenever a zero seed is loaded.

Ports:
- clk  input  1  Single clock. All state updates on its rising edge.
- rst_n  input  1  Synchronous, active-low reset, sampled on the rising edge of clk.
- seed_valid  input  1  Requests a load of seed into the LFSR.
- seed  input  LFSR_W  Seed value.
- start  input  1  Requests generation of one 4-number batch.
- busy  output  1  High in GEN and HOLD.
- out_valid  output  1  Batch on out_number1..4 is valid.
- out_ready  input  1  Consumer accepts the batch.
- out_number1  output  4  First drawn number.
- out_number2  output  4  Second drawn number.
- out_number3  output  4  Third drawn number.
- out_number4  output  4  Fourth drawn number.

Behaviour:
- Interface: one clock. Reset is synchronous and active-low: clk, rst_n.
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, lfsr=DEFAULT_SEED, draw counter=0.
  - busy=0, out_valid=0, out_number1..4=0.
  - Reset mid-GEN or mid-HOLD aborts the batch; no partial output is produced.
- LFSR step: lsb=lfsr[0]; lfsr_next=(lfsr>>1) XOR (lsb ? TAPS : 0).
  - The LFSR steps only in GEN, exactly once per draw.
- Seed load: accepted only in IDLE.
  - If seed_valid=1, lfsr<=seed; if seed==0, lfsr<=DEFAULT_SEED.
  - seed_valid has priority over start in the same cycle: the seed is loaded and start is ignored.
  - seed_valid in GEN or HOLD is ignored.
- States:
  - IDLE: busy=0, out_valid=0. start=1 (with seed_valid=0) -> GEN, counter<=0.
  - GEN: busy=1. Each cycle:
    - out_number[counter+1] <= lfsr[3:0].
    - lfsr <= lfsr_next, counter++.
    - After the 4th draw (counter==3) -> HOLD.
    - start is ignored.
  - HOLD: busy=1, out_valid=1, out_number1..4 stable.
    - out_ready=1 -> IDLE. out_valid=0 and busy=0 from the next cycle.
    - start is ignored, including in the cycle where out_ready=1.
    - out_ready is ignored outside HOLD.
- Latency: start sampled at edge N -> draws at edges N+1..N+4 -> out_valid=1 after edge N+4. Start to valid is 4 cycles.
- Minimum repeat period: 6 cycles (start, 4 draws, 1 handshake cycle back in IDLE).
- Outputs:
  - out_number1..4 keep their last values in IDLE; they are meaningful only while out_valid=1.
  - While in GEN, out_number1..4 may hold a mix of the new batch and the previous batch.
- Sequence continuity: the LFSR is never reset between batches. Consecutive batches continue the same sequence.
- With the defaults, the LFSR never reaches zero. The zero-seed substitution guarantees this.
- All outputs are registered; there are no combinational input-to-output paths.

Test Plan:
- Reset then start pulse, out_ready=1 -> out_valid rises 4 cycles after start; out_number1..4 = 1,0,8,C; internal lfsr = 16'h1C4E.
- Second start after that batch is accepted -> out_number1..4 = E,7,3,9; internal lfsr = 16'hC2C4.
- seed_valid=1 with seed=0 in IDLE, then start -> identical to the post-reset batch (1,0,8,C).
- seed_valid=1 and start=1 in the same IDLE cycle with seed=16'hACE1 -> seed loaded, no GEN entry, busy stays 0. A following start gives 1,0,8,C.
- Hold out_ready=0 for 10 cycles in HOLD while pulsing start and seed_valid -> outputs, out_valid and LFSR unchanged. Raising out_ready returns to IDLE next cycle.
- Assert rst_n=0 on the 2nd GEN cycle -> next cycle busy=0, out_valid=0, outputs 0. The next start produces 1,0,8,C.

Source files
------------

// File: rtl/rand_num_gen.sv
// rtl/rand_num_gen.sv - Galois LFSR drawing four 4-bit random numbers per batch
module rand_num_gen #(
  parameter int unsigned       LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] TAPS         = 16'hB400,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  input  logic [LFSR_W-1:0] seed,
  input  logic              start,
  output logic              busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_number1,
  output logic [3:0]        out_number2,
  output logic [3:0]        out_number3,
  output logic [3:0]        out_number4
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [3:0]        num_q [4];
  logic [3:0]        num_d [4];
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [LFSR_W-1:0] lfsr_step;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  always_comb begin
    lfsr_step = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
  end

  // Next-state, draw and handshake logic; busy/valid are precomputed so the
  // outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (seed_valid) begin
          // A zero seed would lock the LFSR at zero forever.
          lfsr_d = (seed == '0) ? DEFAULT_SEED : seed;
        end else if (start) begin
          state_d = GEN;
          cnt_d   = 2'd0;
          busy_d  = 1'b1;
        end
      end
      GEN: begin
        num_d[cnt_q] = lfsr_q[3:0];
        lfsr_d       = lfsr_step;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d = HOLD;
          valid_d = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset aborts any batch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= DEFAULT_SEED;
      cnt_q   <= 2'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        num_q[i] <= 4'd0;
      end
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      for (int i = 0; i < 4; i++) begin
        num_q[i] <= num_d[i];
      end
    end
  end

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign out_number1 = num_q[0];
  assign out_number2 = num_q[1];
  assign out_number3 = num_q[2];
  assign out_number4 = num_q[3];

endmodule

// File: tb/tb_rand_num_gen.sv
// tb/tb_rand_num_gen.sv - directed self-checking bench for rand_num_gen
module tb_rand_num_gen;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic [15:0] seed;
  logic        start;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_number1, out_number2, out_number3, out_number4;

  int n_cmp = 0;
  int n_bad = 0;

  rand_num_gen dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_valid  (seed_valid),
    .seed        (seed),
    .start       (start),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_number1 (out_number1),
    .out_number2 (out_number2),
    .out_number3 (out_number3),
    .out_number4 (out_number4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_nums(input string tag, input logic [15:0] exp);
    check({tag, " nums"}, {16'h0, out_number1, out_number2, out_number3, out_number4}, {16'h0, exp});
  endtask

  // Pulse start, then wait (bounded) for out_valid and check the 4-cycle latency.
  task automatic start_and_wait(input string tag);
    int cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, " busy_gen"}, {31'h0, busy}, 32'd1);
    cyc = 0;
    while (!out_valid && cyc < 10) begin
      step();
      cyc++;
    end
    check({tag, " latency"}, cyc, 32'd4);
  endtask

  // Full batch with out_ready held high; returns to IDLE one cycle after valid.
  task automatic run_batch(input string tag, input logic [15:0] exp_nums, input logic [15:0] exp_lfsr);
    out_ready = 1'b1;
    start_and_wait(tag);
    check_nums(tag, exp_nums);
    check({tag, " lfsr"}, {16'h0, dut.lfsr_q}, {16'h0, exp_lfsr});
    step();
    check({tag, " idle_valid"}, {31'h0, out_valid}, 32'd0);
    check({tag, " idle_busy"}, {31'h0, busy}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    seed_valid = 1'b0;
    seed       = 16'h0;
    start      = 1'b0;
    out_ready  = 1'b1;
    step();
    step();
    check("rst busy", {31'h0, busy}, 32'd0);
    check("rst valid", {31'h0, out_valid}, 32'd0);
    check_nums("rst", 16'h0000);
    check("rst lfsr", {16'h0, dut.lfsr_q}, 32'h0000ACE1);
    rst_n = 1'b1;
    step();

    run_batch("b1", 16'h108C, 16'h1C4E);
    run_batch("b2", 16'hE739, 16'hC2C4);

    // Zero seed substitutes the default seed.
    seed_valid = 1'b1;
    seed       = 16'h0000;
    step();
    seed_valid = 1'b0;
    check("zseed lfsr", {16'h0, dut.lfsr_q}, 32'h0000ACE1);
    run_batch("b3", 16'h108C, 16'h1C4E);

    // seed_valid wins over start in the same IDLE cycle.
    seed_valid = 1'b1;
    start      = 1'b1;
    seed       = 16'hACE1;
    step();
    seed_valid = 1'b0;
    start      = 1'b0;
    check("prio busy", {31'h0, busy}, 32'd0);
    check("prio lfsr", {16'h0, dut.lfsr_q}, 32'h0000ACE1);
    step();
    check("prio busy2", {31'h0, busy}, 32'd0);
    run_batch("b4", 16'h108C, 16'h1C4E);

    // Back-pressure in HOLD: everything frozen, start/seed_valid ignored.
    seed_valid = 1'b1;
    seed       = 16'hACE1;
    step();
    seed_valid = 1'b0;
    out_ready  = 1'b0;
    start_and_wait("hold");
    for (int i = 0; i < 10; i++) begin
      start      = i[0];
      seed_valid = ~i[0];
      seed       = 16'h1234;
      step();
      check("hold valid", {31'h0, out_valid}, 32'd1);
      check("hold busy", {31'h0, busy}, 32'd1);
      check_nums("hold", 16'h108C);
      check("hold lfsr", {16'h0, dut.lfsr_q}, 32'h00001C4E);
    end
    start      = 1'b1;
    seed_valid = 1'b0;
    out_ready  = 1'b1;
    step();
    start = 1'b0;
    check("release valid", {31'h0, out_valid}, 32'd0);
    check("release busy", {31'h0, busy}, 32'd0);
    step();
    check("release no_restart", {31'h0, busy}, 32'd0);

    // Reset on the second GEN cycle aborts the batch.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort busy", {31'h0, busy}, 32'd0);
    check("abort valid", {31'h0, out_valid}, 32'd0);
    check_nums("abort", 16'h0000);
    check("abort lfsr", {16'h0, dut.lfsr_q}, 32'h0000ACE1);
    run_batch("b5", 16'h108C, 16'h1C4E);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
